// File: rtl/ysyx_23060059_rd_arbiter.sv
// 2:1 single-beat AR/R read arbiter between IFU and LSU, one outstanding read.
// Define RR_ARB_EN for round-robin arbitration; default is fixed LSU > IFU priority.
module ysyx_23060059_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              s_rready
);

  typedef enum logic [1:0] {IDLE, GNT_AR, GNT_R} state_e;

  state_e state_q;
  logic   owner_q;
  logic   win_lsu;

`ifdef RR_ARB_EN
  logic last_gnt_q;
  // On contention the master not granted last time wins.
  always_comb win_lsu = lsu_arvalid && (!ifu_arvalid || !last_gnt_q);
`else
  always_comb win_lsu = lsu_arvalid;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef RR_ARB_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_arvalid || lsu_arvalid) begin
            state_q <= GNT_AR;
            owner_q <= win_lsu;
`ifdef RR_ARB_EN
            last_gnt_q <= win_lsu;
`endif
          end
        end
        GNT_AR: if (s_arvalid && s_arready) state_q <= GNT_R;
        GNT_R:  if (s_rvalid && s_rready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake signals are gated by reset so nothing leaks while it is asserted.
  always_comb begin
    s_arvalid   = 1'b0;
    s_araddr    = owner_q ? lsu_araddr : ifu_araddr;
    s_rready    = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    if (reset) begin
      case (state_q)
        GNT_AR: begin
          s_arvalid   = owner_q ? lsu_arvalid : ifu_arvalid;
          ifu_arready = !owner_q && s_arready;
          lsu_arready = owner_q && s_arready;
        end
        GNT_R: begin
          s_rready   = owner_q ? lsu_rready : ifu_rready;
          ifu_rvalid = !owner_q && s_rvalid;
          lsu_rvalid = owner_q && s_rvalid;
        end
        default: ;
      endcase
    end
  end

  assign ifu_rdata = s_rdata;
  assign lsu_rdata = s_rdata;

endmodule

// File: tb/tb_ysyx_23060059_rd_arbiter.sv
// Directed cycle-by-cycle vector bench for the IFU/LSU read arbiter (default build).
module tb_ysyx_23060059_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr;
  logic [63:0] lsu_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr;
  logic [63:0] s_rdata;

  always #5 clock = ~clock;

  ysyx_23060059_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready)
  );

  typedef struct {
    logic        rst;
    logic        ia;
    logic [31:0] iaddr;
    logic        ir;
    logic        la;
    logic [31:0] laddr;
    logic        lr;
    logic        sar;
    logic        srv;
    logic [63:0] sdata;
    logic        e_sarv;
    logic [31:0] e_saddr;
    logic        e_iar;
    logic        e_lar;
    logic        e_irv;
    logic        e_lrv;
    logic        e_srr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] IA0 = 32'h8000_0000;
  localparam logic [31:0] IA1 = 32'h8000_0004;
  localparam logic [31:0] IA2 = 32'h8000_0008;
  localparam logic [31:0] LA0 = 32'h8000_1000;
  localparam logic [31:0] LA1 = 32'h8000_2000;
  localparam logic [63:0] D0  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D1  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D2  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D3  = 64'hDEAD_BEEF_0000_0001;

  function automatic vec_t mk(logic rst, logic ia, logic [31:0] iaddr, logic ir,
                              logic la, logic [31:0] laddr, logic lr,
                              logic sar, logic srv, logic [63:0] sdata,
                              logic e_sarv, logic [31:0] e_saddr, logic e_iar, logic e_lar,
                              logic e_irv, logic e_lrv, logic e_srr);
    vec_t v;
    v.rst = rst; v.ia = ia; v.iaddr = iaddr; v.ir = ir;
    v.la = la; v.laddr = laddr; v.lr = lr;
    v.sar = sar; v.srv = srv; v.sdata = sdata;
    v.e_sarv = e_sarv; v.e_saddr = e_saddr; v.e_iar = e_iar; v.e_lar = e_lar;
    v.e_irv = e_irv; v.e_lrv = e_lrv; v.e_srr = e_srr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called just after a rising edge: drive, let logic settle, compare, advance one cycle.
  task automatic run_vec(input vec_t v, input string tag);
    logic [5:0] act_f, exp_f;
    reset = v.rst;
    ifu_arvalid = v.ia; ifu_araddr = v.iaddr; ifu_rready = v.ir;
    lsu_arvalid = v.la; lsu_araddr = v.laddr; lsu_rready = v.lr;
    s_arready = v.sar; s_rvalid = v.srv; s_rdata = v.sdata;
    #2;
    act_f = {s_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, s_rready};
    exp_f = {v.e_sarv, v.e_iar, v.e_lar, v.e_irv, v.e_lrv, v.e_srr};
    check({tag, " flags(sarv,iar,lar,irv,lrv,srr)"}, 64'(act_f), 64'(exp_f));
    if (v.e_sarv) check({tag, " s_araddr"}, 64'(s_araddr), 64'(v.e_saddr));
    if (v.e_irv)  check({tag, " ifu_rdata"}, ifu_rdata, v.sdata);
    if (v.e_lrv)  check({tag, " lsu_rdata"}, lsu_rdata, v.sdata);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // rst ia iaddr ir la laddr lr sar srv sdata | sarv saddr iar lar irv lrv srr
    // IFU only read
    vecs.push_back(mk(0,1,IA0,0, 0,LA0,0, 0,0,D0, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,IA0,0, 0,LA0,0, 0,0,D0, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,IA0,0, 0,LA0,0, 1,0,D0, 1,IA0,1,0,0,0,0));
    vecs.push_back(mk(1,0,IA0,1, 0,LA0,0, 0,1,D0, 0,0,  0,0,1,0,1));
    vecs.push_back(mk(1,0,IA0,0, 0,LA0,0, 0,0,D0, 0,0,  0,0,0,0,0));
    // Simultaneous requests: LSU first, bubble, then IFU
    vecs.push_back(mk(1,1,IA1,0, 1,LA0,0, 0,0,D1, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,IA1,0, 1,LA0,0, 1,0,D1, 1,LA0,0,1,0,0,0));
    vecs.push_back(mk(1,1,IA1,1, 0,LA0,1, 0,1,D1, 0,0,  0,0,0,1,1));
    vecs.push_back(mk(1,1,IA1,0, 0,LA0,0, 0,0,D1, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,IA1,0, 0,LA0,0, 0,0,D1, 1,IA1,0,0,0,0,0));
    vecs.push_back(mk(1,1,IA1,0, 0,LA0,0, 1,0,D1, 1,IA1,1,0,0,0,0));
    // Owner holds rready low for two cycles
    vecs.push_back(mk(1,0,IA1,0, 0,LA0,1, 0,1,D2, 0,0,  0,0,1,0,0));
    vecs.push_back(mk(1,0,IA1,0, 0,LA0,1, 0,1,D2, 0,0,  0,0,1,0,0));
    vecs.push_back(mk(1,0,IA1,1, 0,LA0,0, 0,1,D2, 0,0,  0,0,1,0,1));
    vecs.push_back(mk(1,0,IA1,0, 0,LA0,0, 0,0,D2, 0,0,  0,0,0,0,0));
    // Slave stalls AR while LSU requests: IFU grant is held
    vecs.push_back(mk(1,1,IA2,0, 0,LA1,0, 0,0,D3, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,IA2,0, 1,LA1,0, 0,0,D3, 1,IA2,0,0,0,0,0));
    vecs.push_back(mk(1,1,IA2,0, 1,LA1,0, 0,0,D3, 1,IA2,0,0,0,0,0));
    vecs.push_back(mk(1,1,IA2,0, 1,LA1,0, 0,0,D3, 1,IA2,0,0,0,0,0));
    vecs.push_back(mk(1,1,IA2,0, 1,LA1,0, 1,0,D3, 1,IA2,1,0,0,0,0));
    vecs.push_back(mk(1,0,IA2,1, 1,LA1,1, 0,1,D3, 0,0,  0,0,1,0,1));
    vecs.push_back(mk(1,0,IA2,0, 1,LA1,0, 0,0,D3, 0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,0,IA2,0, 1,LA1,0, 1,0,D3, 1,LA1,0,1,0,0,0));
    vecs.push_back(mk(1,0,IA2,0, 0,LA1,1, 0,1,D3, 0,0,  0,0,0,1,1));
    vecs.push_back(mk(1,0,IA2,0, 0,LA1,0, 0,0,D3, 0,0,  0,0,0,0,0));

    reset = 1'b0;
    ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset pulse in GNT_R with the slave presenting data
    run_vec(mk(1,1,IA0,0, 0,LA0,0, 0,0,D0, 0,0,  0,0,0,0,0), "rst_idle");
    run_vec(mk(1,1,IA0,0, 0,LA0,0, 1,0,D0, 1,IA0,1,0,0,0,0), "rst_ar");
    run_vec(mk(0,0,IA0,1, 0,LA0,0, 0,1,D0, 0,0,  0,0,0,0,0), "rst_during");
    run_vec(mk(1,0,IA0,1, 0,LA0,0, 0,1,D0, 0,0,  0,0,0,0,0), "rst_after");
    run_vec(mk(1,1,IA1,0, 0,LA0,0, 0,0,D1, 0,0,  0,0,0,0,0), "post_rst_idle");
    run_vec(mk(1,1,IA1,0, 0,LA0,0, 1,0,D1, 1,IA1,1,0,0,0,0), "post_rst_ar");
    run_vec(mk(1,0,IA1,1, 0,LA0,0, 0,1,D1, 0,0,  0,0,1,0,1), "post_rst_r");

    // Continuous requests from both: fixed priority serves LSU every time
    for (int k = 0; k < 4; k++) begin
      run_vec(mk(1,1,IA0,1, 1,LA1,1, 0,0,D2, 0,0,  0,0,0,0,0), $sformatf("prio%0d_idle", k));
      run_vec(mk(1,1,IA0,1, 1,LA1,1, 1,0,D2, 1,LA1,0,1,0,0,0), $sformatf("prio%0d_ar", k));
      run_vec(mk(1,1,IA0,1, 1,LA1,1, 0,1,D2, 0,0,  0,0,0,1,1), $sformatf("prio%0d_r", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
